// File: rtl/ip_checksum_gen.sv
// Egress IPv4 header checksum insertion for the 64-bit datapath (options-free headers only).
// Latency: 2-entry in-order buffer; an eligible W3 is held until W4 is accepted. out_rdy=0 freezes the output stage.
module ip_checksum_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic                  csum_en,
   output logic [15:0]           num_csum_inserted,
   output logic [15:0]           num_csum_bypassed
);
   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   state_t                state;
   logic [2:0]            idx;
   logic [19:0]           acc;
   logic                  en_q, elig, w4_done, mod_flag, rdy_en;
   logic                  a_vld, a_w3, a_last;
   logic [DATA_WIDTH-1:0] a_dat;
   logic [CTRL_WIDTH-1:0] a_ctl;
   logic                  b_vld, b_w3, b_last;

   logic                  b_emit, shift, accept, ctl_zero, start, body, last, w4_ok;
   logic                  elig_n, w4_done_n, b_vld_n, b_w3_n;
   logic [19:0]           acc_add, acc_sum;
   logic [15:0]           csum_w4;

   function automatic logic [15:0] fold_csum(input logic [19:0] a);
      logic [16:0] s1;
      logic [15:0] s2;
      s1 = {1'b0, a[15:0]} + {13'd0, a[19:16]};
      s2 = s1[15:0] + {15'd0, s1[16]};
      return ~s2;
   endfunction

   always_comb begin
      b_emit   = out_wr & out_rdy;
      shift    = a_vld & (~b_vld | b_emit);
      in_rdy   = rdy_en & (~a_vld | shift);
      accept   = in_wr & in_rdy;
      ctl_zero = (in_ctrl == '0);
      start    = accept & ctl_zero & (state != BODY);
      body     = accept & (state == BODY);
      last     = body & ~ctl_zero;
      case (idx)
         3'd1:    acc_add = 20'(in_data[15:0]);
         3'd2:    acc_add = 20'(in_data[63:48]) + 20'(in_data[47:32])
                          + 20'(in_data[31:16]) + 20'(in_data[15:0]);
         3'd3:    acc_add = 20'(in_data[47:32]) + 20'(in_data[31:16]) + 20'(in_data[15:0]);
         3'd4:    acc_add = 20'(in_data[63:48]);
         default: acc_add = '0;
      endcase
      acc_sum = acc + acc_add;
      csum_w4 = fold_csum(acc_sum);
      w4_ok   = body & ctl_zero & (idx == 3'd4) & elig;

      elig_n = elig;
      if (start)
         elig_n = 1'b0;
      else if (body && idx == 3'd1)
         elig_n = ctl_zero & (in_data[31:16] == 16'h0800) & (in_data[15:8] == 8'h45) & en_q;
      else if (last && idx <= 3'd4)
         elig_n = 1'b0;
      w4_done_n = ~start & (w4_done | w4_ok);
      b_vld_n   = shift | (b_vld & ~b_emit);
      b_w3_n    = shift ? a_w3 : b_w3;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state             <= IDLE;
         idx               <= '0;
         acc               <= '0;
         en_q              <= 1'b0;
         elig              <= 1'b0;
         w4_done           <= 1'b0;
         mod_flag          <= 1'b0;
         rdy_en            <= 1'b0;
         a_vld             <= 1'b0;
         a_w3              <= 1'b0;
         a_last            <= 1'b0;
         a_dat             <= '0;
         a_ctl             <= '0;
         b_vld             <= 1'b0;
         b_w3              <= 1'b0;
         b_last            <= 1'b0;
         out_data          <= '0;
         out_ctrl          <= '0;
         out_wr            <= 1'b0;
         num_csum_inserted <= '0;
         num_csum_bypassed <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (accept) begin
            a_dat  <= in_data;
            a_ctl  <= in_ctrl;
            a_w3   <= body & (idx == 3'd3);
            a_last <= last;
            a_vld  <= 1'b1;
         end else if (shift) begin
            a_vld <= 1'b0;
         end
         b_vld <= b_vld_n;
         b_w3  <= b_w3_n;
         if (shift) begin
            out_data <= a_dat;
            out_ctrl <= a_ctl;
            b_last   <= a_last;
         end
         // W3 is either already parked in B or moving into it on the edge that accepts W4.
         if (w4_ok)
            out_data[63:48] <= csum_w4;
         out_wr  <= b_vld_n & ~(b_w3_n & elig_n & ~w4_done_n);
         elig    <= elig_n;
         w4_done <= w4_done_n;

         if (start) begin
            en_q <= csum_en;
            idx  <= 3'd1;
            acc  <= '0;
         end else if (body) begin
            acc <= acc_sum;
            if (idx < 3'd5)
               idx <= idx + 3'd1;
         end

         case (state)
            IDLE:    if (start) state <= BODY;
                     else if (accept && in_ctrl == '1) state <= HDR;
            HDR:     if (start) state <= BODY;
            BODY:    if (last) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (b_emit && b_last) begin
            if (mod_flag)
               num_csum_inserted <= num_csum_inserted + 16'd1;
            else
               num_csum_bypassed <= num_csum_bypassed + 16'd1;
            mod_flag <= 1'b0;
         end else if (b_emit && b_w3) begin
            mod_flag <= elig;
         end
      end
   end
endmodule

// File: doc/ip_checksum_gen.md
# ip_checksum_gen

Transmit-side IPv4 header checksum generator for the 64-bit packet datapath. It sits before the output queues/MAC on the egress path. For every IPv4 packet without options it computes the 16-bit one's-complement header checksum and writes it into the checksum field. It mirrors the ingress checksum/TTL checker, so any header this block emits passes that checker with a sum of 0xFFFF.

## Interface
Parameters:
- DATA_WIDTH, 64, datapath width; only 64 is supported.
- CTRL_WIDTH, 8, control sideband width.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-low; 0 = reset, sampled on the clk rising edge.
- in_data  in  64  input word.
- in_ctrl  in  8  input control. 0xFF = module header word; 0x00 = packet body; any other nonzero value after the body has started = last word.
- in_wr  in  1  input word valid.
- in_rdy  out  1  block can accept a word this cycle.
- out_data  out  64  output word.
- out_ctrl  out  8  output control, passed through unchanged.
- out_wr  out  1  output word valid.
- out_rdy  in  1  downstream can accept a word.
- csum_en  in  1  1 = insert the checksum; 0 = pass every packet unmodified. Sampled on the first body word and held for the whole packet.
- num_csum_inserted  out  16  wrapping count of packets modified.
- num_csum_bypassed  out  16  wrapping count of packets passed unmodified.

## Operation
Body word layout (body word index k counts ctrl==0 words from 0):
- W1[31:16] = ethertype; W1[15:0] = version/IHL and TOS.
- W2 = total length, ID, frag, TTL/proto.
- W3[63:48] = checksum field; W3[47:0] = src IP and dst IP high half.
- W4[63:48] = dst IP low half.

Eligibility is decided at W1: ethertype == 0x0800, W1[15:8] == 0x45, and csum_en == 1. All other packets are bypassed and pass through bit-exact.

Accumulator: 20 bits, cleared on the first body word. For eligible packets it adds the following 16-bit fields, 9 in total, so the sum is at most 9×0xFFFF < 2^20:
- W1[15:0]
- the four 16-bit fields of W2
- W3[47:32], W3[31:16], W3[15:0]
- W4[63:48]

The incoming checksum field is ignored.

Final checksum:
- s1 = acc[15:0] + acc[19:16] (17 bits)
- s2 = s1[15:0] + s1[16]
- csum = ~s2[15:0]

Pipeline: a 2-entry in-order buffer, stage A (newest) and stage B (oldest).
- Stage B drives out_data, out_ctrl, and out_wr = valid_B.
- Hold rule: if stage B holds W3 of an eligible packet and W4 has not yet been accepted, valid_B is presented as 0 (out_wr = 0).
- When W3 is emitted, out_data = {csum, W3[47:0]}.
- in_rdy = !valid_A | (stage A shifts this cycle).
- Stage A shifts into B whenever B is empty or B emits.

Truncated packet: if the last word arrives at or before W4, the packet is bypassed and W3, if present, is released unmodified.

Counters:
- Each packet increments exactly one counter, on the cycle its last word is emitted.
- Both counters wrap at 16 bits.

Packet tracking FSM, advanced on accepted input words:
- IDLE -> HDR on ctrl 0xFF.
- IDLE or HDR -> BODY on ctrl 0x00; the word index and accumulator are reset here.
- BODY -> IDLE on the last word.

## Timing
- Reset values: out_wr = 0, in_rdy = 0, both counters = 0, both stages empty, FSM = IDLE. in_rdy rises to 1 on the first cycle after reset deasserts.
- Latency: with out_rdy held at 1, a word accepted in cycle t appears on out_* no earlier than cycle t+1. W3 appears no earlier than the cycle after W4 is accepted.
- Full throughput: with in_wr = 1 and out_rdy = 1 continuously, the block accepts one word per cycle with no bubbles.
- Backpressure: out_rdy = 0 freezes stage B. in_rdy falls only when both stages are full.
- Output stability: out_data, out_ctrl, and out_wr are registered and do not change while out_wr = 1 and out_rdy = 0.
- Drain: after a last word is accepted, the buffer drains without further input.
- Next packet: a new packet's module header may be accepted while the previous packet's words are still buffered. Accumulator and eligibility state are per-packet and are not overwritten until the held W3 has been released.
- Reset mid-packet: partial packets are dropped and the pipeline is empty on the first cycle after reset.

## Test plan
- Standard header 45 00 00 73 00 00 40 00 40 11 [csum 0x0000] c0 a8 00 01 c0 a8 00 c7, in_rdy and out_rdy held at 1 -> W3[63:48] out = 0xB861; all other words bit-exact; num_csum_inserted = 1.
- Same packet with the incoming checksum field = 0xABCD -> output is still 0xB861.
- Ver/IHL = 0x46, and separately ethertype 0x0806 -> output identical to input; num_csum_bypassed increments by 1 for each.
- csum_en = 0 on an eligible packet -> unmodified. Toggling csum_en mid-packet has no effect.
- Random out_rdy (50%) over 1000 back-to-back packets -> no lost, duplicated, or reordered words; every eligible header re-checks to 0xFFFF.
- Packet whose last word is W3 -> W3 emitted unmodified and the bypass counter increments. Reset asserted during W2 -> out_wr = 0 on the next cycle and the next packet is processed correctly.
